clock_divider: RTL

Synthesizable programmable clock divider placed directly downstream of the behavioural `clock` generator. It runs on the generated `clk` and produces a divided square wave `clk_out` plus a one-cycle `tick` strobe at the start of each output period. The divisor and high-time are runtime-programmable. New settings take effect only on a period boundary, and disabling the divider lets the current period finish before it stops.

---
 rtl/clock_div_pkg.sv | 15 +
 rtl/div_settings.sv | 71 +++++++
 rtl/clock_divider.sv | 99 +++++++++
 3 files changed

// File: rtl/clock_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding and
// reset/clamp constants used by the top level and the settings block.
package clock_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DIV_MIN  = 2;
    localparam int DIV_RST  = 2;
    localparam int HIGH_RST = 1;

endpackage

// File: rtl/div_settings.sv
// Divisor/high-time settings: captures and clamps loads, holds them pending,
// and promotes them to the active set on a period boundary (or at once in IDLE).
module div_settings
    import clock_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    input  logic             boundary,
    input  logic             idle,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] high_nxt,
    output logic             pending
);

    logic [WIDTH-1:0] div_p, high_p;
    logic [WIDTH-1:0] div_nxt, div_p_n, high_p_n, div_clamped;
    logic [WIDTH-1:0] high_a;
    logic             pending_n;

    assign div_clamped = (div_in < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : div_in;

    // A load arriving on the boundary edge bypasses the pending registers
    // so the period that starts on that edge already uses it.
    always_comb begin
        div_nxt   = div_a;
        high_nxt  = high_a;
        div_p_n   = div_p;
        high_p_n  = high_p;
        pending_n = pending;
        if (boundary) begin
            if (load) begin
                div_nxt  = div_clamped;
                high_nxt = high_in;
            end else if (pending) begin
                div_nxt  = div_p;
                high_nxt = high_p;
            end
            pending_n = 1'b0;
        end else if (load) begin
            div_p_n   = div_clamped;
            high_p_n  = high_in;
            pending_n = 1'b1;
        end else if (idle && pending) begin
            div_nxt   = div_p;
            high_nxt  = high_p;
            pending_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_a   <= WIDTH'(DIV_RST);
            high_a  <= WIDTH'(HIGH_RST);
            div_p   <= WIDTH'(DIV_RST);
            high_p  <= WIDTH'(HIGH_RST);
            pending <= 1'b0;
        end else begin
            div_a   <= div_nxt;
            high_a  <= high_nxt;
            div_p   <= div_p_n;
            high_p  <= high_p_n;
            pending <= pending_n;
        end
    end

endmodule

// File: rtl/clock_divider.sv
// Programmable clock divider: produces clk_out and a period-start tick from clk,
// switching settings only on period boundaries and draining before it stops.
module clock_divider
    import clock_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic             pending,
    output logic [WIDTH-1:0] periods
);

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n, div_a, high_nxt;
    logic             wrap, idle, boundary, start, run_n;
    logic             clk_out_n, tick_n;

    assign idle     = (state == IDLE);
    assign wrap     = !idle && (cnt == div_a - WIDTH'(1));
    assign boundary = wrap || (idle && enable);
    assign running  = !idle;

    div_settings #(.WIDTH(WIDTH)) u_settings (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .div_in   (div_in),
        .high_in  (high_in),
        .boundary (boundary),
        .idle     (idle),
        .div_a    (div_a),
        .high_nxt (high_nxt),
        .pending  (pending)
    );

    // DRAIN only records that enable dropped; the period always runs to its wrap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = RUN;
                    start   = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (wrap) begin
                    cnt_n = '0;
                    if (enable) begin
                        state_n = RUN;
                        start   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n   = cnt + WIDTH'(1);
                    state_n = enable ? RUN : DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        run_n     = (state_n != IDLE);
        clk_out_n = run_n && (cnt_n < high_nxt);
        tick_n    = run_n && (cnt_n == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            periods <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            clk_out <= clk_out_n;
            tick    <= tick_n;
            if (start) begin
                periods <= periods + WIDTH'(1);
            end
        end
    end

endmodule
